unidade_controle: RTL and testbench

Multicycle control unit for the RISC-V datapath in `principal`. A Moore state machine with Mealy qualifiers on memory handshake and branch resolution. It sequences fetch, decode, execute, memory and write-back for a fixed RV64 subset, and drives every mux select and write enable in the datapath. It exports its state on `stateOut` for bench monitoring.

---
 rtl/unidade_controle.sv | 241 ++++++++++++++++++++++++
 tb/tb_unidade_controle.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Multicycle control unit for the RV64 subset datapath in principal.
// Moore sequencing; memory handshake, branch outcome and funct fields qualify some outputs.
module unidade_controle #(
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [4:0] stateOut,
    output logic       pc_write,
    output logic       ir_write,
    output logic       load_ab,
    output logic       aluout_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_srcA,
    output logic [1:0] alu_srcB,
    output logic [2:0] alu_op,
    output logic [1:0] mux_wd,
    output logic       illegal
);

    localparam logic [4:0] StReset  = 5'd0;
    localparam logic [4:0] StFetch  = 5'd1;
    localparam logic [4:0] StDecode = 5'd2;
    localparam logic [4:0] StExecR  = 5'd3;
    localparam logic [4:0] StWbR    = 5'd4;
    localparam logic [4:0] StExecI  = 5'd5;
    localparam logic [4:0] StWbI    = 5'd6;
    localparam logic [4:0] StAddr   = 5'd7;
    localparam logic [4:0] StMemRd  = 5'd8;
    localparam logic [4:0] StWbLd   = 5'd9;
    localparam logic [4:0] StMemWr  = 5'd10;
    localparam logic [4:0] StBranch = 5'd11;
    localparam logic [4:0] StLui    = 5'd12;
    localparam logic [4:0] StJal    = 5'd13;
    localparam logic [4:0] StExcept = 5'd31;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluAnd   = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;

    localparam logic [1:0] SrcBReg  = 2'd0;
    localparam logic [1:0] SrcBFour = 2'd1;
    localparam logic [1:0] SrcBImm  = 2'd2;

    localparam logic [1:0] WdAluOut = 2'd0;
    localparam logic [1:0] WdMdr    = 2'd1;
    localparam logic [1:0] WdPc     = 2'd2;
    localparam logic [1:0] WdImm    = 2'd3;

    localparam logic [4:0] StIllegalNext = (ILLEGAL_HALT != 0) ? StExcept : StFetch;

    logic [4:0] state_q, state_d;
    logic       dec_legal;
    logic [4:0] dec_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    assign stateOut = state_q;

    // Opcode decode; a recognised opcode with an unsupported funct3 is still illegal.
    always_comb begin
        dec_legal = 1'b1;
        dec_next  = StIllegalNext;
        case (opcode)
            OpR:      dec_next = StExecR;
            OpI:      dec_next = StExecI;
            OpLoad: begin
                dec_next  = StAddr;
                dec_legal = (funct3 == 3'b011);
            end
            OpStore: begin
                dec_next  = StAddr;
                dec_legal = (funct3 == 3'b011);
            end
            OpBranch: begin
                dec_next  = StBranch;
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            OpLui:    dec_next = StLui;
            OpJal:    dec_next = StJal;
            default:  dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        load_ab      = 1'b0;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        alu_srcA     = 1'b0;
        alu_srcB     = SrcBReg;
        alu_op       = AluAdd;
        mux_wd       = WdAluOut;
        illegal      = 1'b0;

        case (state_q)
            StReset: state_d = StFetch;

            StFetch: begin
                mem_read = 1'b1;
                alu_srcB = SrcBFour;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end

            StDecode: begin
                if (dec_legal) begin
                    load_ab      = 1'b1;
                    aluout_write = 1'b1;
                    alu_srcB     = SrcBImm;
                    state_d      = dec_next;
                end else begin
                    illegal = 1'b1;
                    state_d = StIllegalNext;
                end
            end

            StExecR: begin
                alu_srcA     = 1'b1;
                alu_srcB     = SrcBReg;
                aluout_write = 1'b1;
                state_d      = StWbR;
                case (funct3)
                    3'b000:  alu_op = funct7_5 ? AluSub : AluAdd;
                    3'b111:  alu_op = AluAnd;
                    3'b110:  alu_op = AluOr;
                    default: begin
                        alu_srcA     = 1'b0;
                        aluout_write = 1'b0;
                        illegal      = 1'b1;
                        state_d      = StIllegalNext;
                    end
                endcase
            end

            StExecI: begin
                if (funct3 == 3'b000) begin
                    alu_srcA     = 1'b1;
                    alu_srcB     = SrcBImm;
                    aluout_write = 1'b1;
                    state_d      = StWbI;
                end else begin
                    illegal = 1'b1;
                    state_d = StIllegalNext;
                end
            end

            StWbR, StWbI: begin
                reg_write = 1'b1;
                mux_wd    = WdAluOut;
                state_d   = StFetch;
            end

            StAddr: begin
                alu_srcA     = 1'b1;
                alu_srcB     = SrcBImm;
                aluout_write = 1'b1;
                state_d      = (opcode == OpStore) ? StMemWr : StMemRd;
            end

            StMemRd: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    mdr_write = 1'b1;
                    state_d   = StWbLd;
                end
            end

            StWbLd: begin
                reg_write = 1'b1;
                mux_wd    = WdMdr;
                state_d   = StFetch;
            end

            StMemWr: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end

            // PC takes the target held in ALUOut from decode.
            StBranch: begin
                alu_srcA = 1'b1;
                alu_srcB = SrcBReg;
                alu_op   = AluSub;
                pc_write = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
                state_d  = StFetch;
            end

            StLui: begin
                reg_write = 1'b1;
                mux_wd    = WdImm;
                state_d   = StFetch;
            end

            StJal: begin
                reg_write = 1'b1;
                mux_wd    = WdPc;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end

            StExcept: illegal = 1'b1;

            default: state_d = StReset;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed-vector bench for unidade_controle: state sequences and per-state controls.
module tb_unidade_controle;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic [4:0] stateOut;
    logic       pc_write, ir_write, load_ab, aluout_write, mdr_write;
    logic       reg_write, mem_read, mem_write, alu_srcA, illegal;
    logic [1:0] alu_srcB;
    logic [2:0] alu_op;
    logic [1:0] mux_wd;
    logic [8:0] en;

    int checks = 0;
    int errors = 0;

    assign en = {pc_write, ir_write, load_ab, aluout_write, mdr_write,
                 reg_write, mem_read, mem_write, illegal};

    unidade_controle #(.ILLEGAL_HALT(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .stateOut(stateOut), .pc_write(pc_write),
        .ir_write(ir_write), .load_ab(load_ab), .aluout_write(aluout_write),
        .mdr_write(mdr_write), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_op(alu_op),
        .mux_wd(mux_wd), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (stateOut !== 5'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", stateOut);
        end
        checks++;
        if (en !== 9'd0 || mux_wd !== 2'd0 || alu_op !== 3'd0 || alu_srcB !== 2'd0) begin
            errors++; $display("FAIL reset_outputs: got en=%b expected 0", en);
        end
        reset = 1'b1;
        step();
        checks++;
        if (stateOut !== 5'd1) begin
            errors++; $display("FAIL reset_first_fetch: got %0d expected 1", stateOut);
        end
    endtask

    task automatic test_add();
        logic [4:0] seq [5];
        seq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (stateOut !== seq[i]) begin
                errors++; $display("FAIL add_seq[%0d]: got %0d expected %0d", i, stateOut, seq[i]);
            end
            checks++;
            if (reg_write !== (seq[i] == 5'd4)) begin
                errors++; $display("FAIL add_reg_write[%0d]: got %0b", i, reg_write);
            end
            if (seq[i] == 5'd3) begin
                checks++;
                if (alu_op !== 3'b000 || aluout_write !== 1'b1 || alu_srcA !== 1'b1) begin
                    errors++; $display("FAIL add_exec: got op=%b aw=%b", alu_op, aluout_write);
                end
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_sub();
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1; mem_ready = 1'b1;
        step(); step();
        checks++;
        if (stateOut !== 5'd3 || alu_op !== 3'b001) begin
            errors++; $display("FAIL sub_exec: got st=%0d op=%b expected 3/001", stateOut, alu_op);
        end
        funct3 = 3'b110;
        #1;
        checks++;
        if (alu_op !== 3'b011) begin
            errors++; $display("FAIL or_exec: got op=%b expected 011", alu_op);
        end
        step(); step();
        funct7_5 = 1'b0;
    endtask

    task automatic test_ld();
        opcode = 7'b0000011; funct3 = 3'b011; mem_ready = 1'b1;
        step();
        checks++;
        if (stateOut !== 5'd2 || load_ab !== 1'b1 || alu_srcB !== 2'd2) begin
            errors++; $display("FAIL ld_decode: got st=%0d ab=%b", stateOut, load_ab);
        end
        step();
        checks++;
        if (stateOut !== 5'd7 || aluout_write !== 1'b1) begin
            errors++; $display("FAIL ld_addr: got st=%0d expected 7", stateOut);
        end
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (stateOut !== 5'd8 || mem_read !== 1'b1 || mdr_write !== 1'b0) begin
                errors++; $display("FAIL ld_wait[%0d]: got st=%0d mdr=%b", k, stateOut, mdr_write);
            end
        end
        step();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (stateOut !== 5'd8 || mdr_write !== 1'b1) begin
            errors++; $display("FAIL ld_ready: got st=%0d mdr=%b expected 8/1", stateOut, mdr_write);
        end
        step();
        checks++;
        if (stateOut !== 5'd9 || reg_write !== 1'b1 || mux_wd !== 2'd1) begin
            errors++; $display("FAIL ld_wb: got st=%0d wd=%0d expected 9/1", stateOut, mux_wd);
        end
        step();
        checks++;
        if (stateOut !== 5'd1) begin
            errors++; $display("FAIL ld_end: got %0d expected 1", stateOut);
        end
    endtask

    task automatic test_sd();
        opcode = 7'b0100011; funct3 = 3'b011; mem_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (stateOut !== 5'd10 || mem_write !== 1'b1 || reg_write !== 1'b0) begin
            errors++; $display("FAIL sd_mem: got st=%0d mw=%b rw=%b", stateOut, mem_write, reg_write);
        end
        step();
        checks++;
        if (stateOut !== 5'd1) begin
            errors++; $display("FAIL sd_end: got %0d expected 1", stateOut);
        end
    endtask

    task automatic test_branch();
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (ir_write !== 1'b0 || mem_read !== 1'b1) begin
            errors++; $display("FAIL fetch_wait: got ir=%b expected 0", ir_write);
        end
        step();
        checks++;
        if (stateOut !== 5'd1) begin
            errors++; $display("FAIL fetch_hold: got %0d expected 1", stateOut);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
            errors++; $display("FAIL fetch_ready: got ir=%b pc=%b expected 1/1", ir_write, pc_write);
        end
        step(); step();
        checks++;
        if (stateOut !== 5'd11 || pc_write !== 1'b1 || alu_op !== 3'b001) begin
            errors++; $display("FAIL beq_taken: got st=%0d pc=%b", stateOut, pc_write);
        end
        step();
        funct3 = 3'b001;
        step(); step();
        checks++;
        if (stateOut !== 5'd11 || pc_write !== 1'b0) begin
            errors++; $display("FAIL bne_not_taken: got st=%0d pc=%b expected 11/0", stateOut, pc_write);
        end
        zero = 1'b0;
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL bne_taken: got pc=%b expected 1", pc_write);
        end
        step();
        checks++;
        if (stateOut !== 5'd1) begin
            errors++; $display("FAIL branch_end: got %0d expected 1", stateOut);
        end
    endtask

    task automatic test_lui();
        opcode = 7'b0110111; mem_ready = 1'b1;
        step(); step();
        checks++;
        if (stateOut !== 5'd12 || reg_write !== 1'b1 || mux_wd !== 2'd3) begin
            errors++; $display("FAIL lui: got st=%0d wd=%0d expected 12/3", stateOut, mux_wd);
        end
        step();
    endtask

    task automatic test_jal();
        logic [4:0] seq [4];
        seq = '{5'd1, 5'd2, 5'd13, 5'd1};
        opcode = 7'b1101111; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (stateOut !== seq[i]) begin
                errors++; $display("FAIL jal_seq[%0d]: got %0d expected %0d", i, stateOut, seq[i]);
            end
            if (seq[i] == 5'd13) begin
                checks++;
                if (mux_wd !== 2'd2 || reg_write !== 1'b1 || pc_write !== 1'b1 || mem_write !== 1'b0)
                begin
                    errors++; $display("FAIL jal_ctrl: got wd=%0d rw=%b pc=%b", mux_wd, reg_write,
                                       pc_write);
                end
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_reset_mid();
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (stateOut !== 5'd4 || reg_write !== 1'b1) begin
            errors++; $display("FAIL mid_setup: got st=%0d expected 4", stateOut);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (stateOut !== 5'd0 || en !== 9'd0) begin
            errors++; $display("FAIL mid_abort: got st=%0d en=%b expected 0/0", stateOut, en);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (stateOut !== 5'd1) begin
            errors++; $display("FAIL mid_restart: got %0d expected 1", stateOut);
        end
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111; mem_ready = 1'b1;
        step();
        checks++;
        if (stateOut !== 5'd2 || illegal !== 1'b1 || load_ab !== 1'b0 || aluout_write !== 1'b0) begin
            errors++; $display("FAIL illegal_decode: got st=%0d ill=%b ab=%b", stateOut, illegal,
                               load_ab);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (stateOut !== 5'd31 || en !== 9'b000000001) begin
                errors++; $display("FAIL illegal_hold[%0d]: got st=%0d en=%b expected 31/000000001",
                                   k, stateOut, en);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (stateOut !== 5'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_reset: got st=%0d ill=%b expected 0/0", stateOut, illegal);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (stateOut !== 5'd1) begin
            errors++; $display("FAIL illegal_restart: got %0d expected 1", stateOut);
        end
    endtask

    initial begin
        reset = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_ld();
        test_sd();
        test_branch();
        test_lui();
        test_jal();
        test_reset_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
